// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/MEM shared-RAM arbiter: bus widths,
// FSM state encoding and owner encoding.
package mem_arbiter_pkg;

  localparam int ADDR_BUS    = 32;
  localparam int DATA_BUS    = 32;
  localparam int MEM_SEL_BUS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving an instruction-fetch port and a data-memory port
// exclusive, fixed-latency access to a single shared RAM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req,
  input  logic [ADDR_BUS-1:0]    if_addr,
  output logic                   if_done,
  output logic [DATA_BUS-1:0]    if_rdata,
  input  logic                   mem_req,
  input  logic [ADDR_BUS-1:0]    mem_addr,
  input  logic [MEM_SEL_BUS-1:0] mem_write_en,
  input  logic [DATA_BUS-1:0]    mem_write_data,
  output logic                   mem_done,
  output logic [DATA_BUS-1:0]    mem_rdata,
  output logic                   ram_en,
  output logic [MEM_SEL_BUS-1:0] ram_write_en,
  output logic [ADDR_BUS-1:0]    ram_addr,
  output logic [DATA_BUS-1:0]    ram_write_data,
  input  logic [DATA_BUS-1:0]    ram_read_data,
  output logic                   stall_if,
  output logic                   stall_mem,
  output logic [1:0]             dbg_state
);

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  // Handshake: a side raises req with addr/data and holds them until its done
  // pulse; they are sampled only in IDLE, and a later drop of req never aborts.
  state_e                 state_q;
  owner_e                 owner_q;
  owner_e                 last_grant_q;
  logic [3:0]             cnt_q;
  logic                   ram_en_q;
  logic [MEM_SEL_BUS-1:0] ram_we_q;
  logic [ADDR_BUS-1:0]    ram_addr_q;
  logic [DATA_BUS-1:0]    ram_wdata_q;
  logic                   if_done_q;
  logic                   mem_done_q;
  logic [DATA_BUS-1:0]    if_rdata_q;
  logic [DATA_BUS-1:0]    mem_rdata_q;

  logic   grant_valid_d;
  owner_e grant_owner_d;

  always_comb begin
    grant_valid_d = if_req | mem_req;
    grant_owner_d = OWN_IF;
    if (if_req && mem_req) begin
      grant_owner_d = (last_grant_q == OWN_IF) ? OWN_MEM : OWN_IF;
    end else if (mem_req) begin
      grant_owner_d = OWN_MEM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_IF;
      cnt_q        <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= '0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            state_q      <= ST_ACCESS;
            owner_q      <= grant_owner_d;
            last_grant_q <= grant_owner_d;
            cnt_q        <= '0;
            ram_en_q     <= 1'b1;
            if (grant_owner_d == OWN_MEM) begin
              ram_addr_q  <= mem_addr;
              ram_we_q    <= mem_write_en;
              ram_wdata_q <= mem_write_data;
            end else begin
              ram_addr_q  <= if_addr;
              ram_we_q    <= '0;
              ram_wdata_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            // All-zero byte enables mark a read; writes leave rdata untouched.
            if (ram_we_q == '0) begin
              if (owner_q == OWN_IF) if_rdata_q  <= ram_read_data;
              else                   mem_rdata_q <= ram_read_data;
            end
            state_q    <= ST_DONE;
            ram_en_q   <= 1'b0;
            ram_we_q   <= '0;
            if_done_q  <= (owner_q == OWN_IF);
            mem_done_q <= (owner_q == OWN_MEM);
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          if_done_q  <= 1'b0;
          mem_done_q <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_done        = if_done_q;
  assign mem_done       = mem_done_q;
  assign if_rdata       = if_rdata_q;
  assign mem_rdata      = mem_rdata_q;
  assign ram_en         = ram_en_q;
  assign ram_write_en   = ram_we_q;
  assign ram_addr       = ram_addr_q;
  assign ram_write_data = ram_wdata_q;
  assign stall_if       = if_req && !if_done_q;
  assign stall_mem      = mem_req && !mem_done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: four instances (LATENCY 2, 4, 1, 15) sharing one clock,
// each with a behavioural RAM; directed tables, corner sequences and a random run.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst            [N];
  logic                   if_req         [N];
  logic [ADDR_BUS-1:0]    if_addr        [N];
  logic                   if_done        [N];
  logic [DATA_BUS-1:0]    if_rdata       [N];
  logic                   mem_req        [N];
  logic [ADDR_BUS-1:0]    mem_addr       [N];
  logic [MEM_SEL_BUS-1:0] mem_write_en   [N];
  logic [DATA_BUS-1:0]    mem_write_data [N];
  logic                   mem_done       [N];
  logic [DATA_BUS-1:0]    mem_rdata      [N];
  logic                   ram_en         [N];
  logic [MEM_SEL_BUS-1:0] ram_write_en   [N];
  logic [ADDR_BUS-1:0]    ram_addr       [N];
  logic [DATA_BUS-1:0]    ram_write_data [N];
  logic [DATA_BUS-1:0]    ram_read_data  [N];
  logic                   stall_if       [N];
  logic                   stall_mem      [N];
  logic [1:0]             dbg_state      [N];

  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(
      .LATENCY((g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 1 : 15)
    ) u_dut (
      .clk            (clk),
      .rst            (rst[g]),
      .if_req         (if_req[g]),
      .if_addr        (if_addr[g]),
      .if_done        (if_done[g]),
      .if_rdata       (if_rdata[g]),
      .mem_req        (mem_req[g]),
      .mem_addr       (mem_addr[g]),
      .mem_write_en   (mem_write_en[g]),
      .mem_write_data (mem_write_data[g]),
      .mem_done       (mem_done[g]),
      .mem_rdata      (mem_rdata[g]),
      .ram_en         (ram_en[g]),
      .ram_write_en   (ram_write_en[g]),
      .ram_addr       (ram_addr[g]),
      .ram_write_data (ram_write_data[g]),
      .ram_read_data  (ram_read_data[g]),
      .stall_if       (stall_if[g]),
      .stall_mem      (stall_mem[g]),
      .dbg_state      (dbg_state[g])
    );
    assign ram_read_data[g] = ram_fn(ram_addr[g]);
  end

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt[6];
  bit   lg[N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction with per-cycle checks of the RAM-side bus.
  task automatic do_txn(input int g, input bit is_mem, input logic [31:0] addr,
                        input logic [3:0] we, input logic [31:0] wdata);
    int lat;
    int n;
    int en_cycles;
    bit seen;
    lat = lat_of(g);
    n = 0;
    en_cycles = 0;
    seen = 0;
    if (is_mem) begin
      mem_req[g] = 1; mem_addr[g] = addr; mem_write_en[g] = we; mem_write_data[g] = wdata;
    end else begin
      if_req[g] = 1; if_addr[g] = addr;
    end
    #1;
    chk("stall_before", is_mem ? stall_mem[g] : stall_if[g], 1);
    while (!seen && n < lat + 8) begin
      tick();
      n++;
      if (ram_en[g]) begin
        en_cycles++;
        chk("ram_addr", ram_addr[g], addr);
        chk("ram_we", 32'(ram_write_en[g]), is_mem ? 32'(we) : 32'd0);
        chk("ram_wdata", ram_write_data[g], is_mem ? wdata : 32'd0);
      end
      chk("other_done", is_mem ? if_done[g] : mem_done[g], 0);
      if ((is_mem ? mem_done[g] : if_done[g]) === 1'b1) seen = 1;
      else chk("stall_wait", is_mem ? stall_mem[g] : stall_if[g], 1);
    end
    chk("done_seen", seen, 1);
    chk("latency", n, lat + 1);
    chk("access_len", en_cycles, lat);
    chk("stall_at_done", is_mem ? stall_mem[g] : stall_if[g], 0);
    chk("ram_en_at_done", ram_en[g], 0);
    chk("ram_we_at_done", 32'(ram_write_en[g]), 0);
    if (is_mem) mem_req[g] = 0; else if_req[g] = 0;
    tick();
    chk("done_pulse_width", is_mem ? mem_done[g] : if_done[g], 0);
    chk("back_to_idle", dbg_state[g], 0);
    lg[g] = is_mem;
  endtask

  task automatic wait_done(input int g, input int budget, output bit got, output bit owner,
                           output int n);
    got = 0;
    owner = 0;
    n = 0;
    while (!got && n < budget) begin
      tick();
      n++;
      chk("both_done", if_done[g] & mem_done[g], 0);
      if (if_done[g]) begin got = 1; owner = 0; end
      else if (mem_done[g]) begin got = 1; owner = 1; end
    end
    chk("done_seen", got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    bit          own;
    bit          w;
    bit          first;
    bit          any_done;
    int          n;
    int          l0;
    logic [31:0] e;
    logic [32:0] eq;
    logic [31:0] m_if_rd;
    logic [31:0] m_mem_rd;
    bit          pend[2];
    logic [31:0] p_addr[2];
    logic [3:0]  p_we;
    logic [31:0] p_wd;

    l0 = lat_of(0);
    for (int g = 0; g < N; g++) begin
      rst[g] = 1; if_req[g] = 0; if_addr[g] = '0; mem_req[g] = 0;
      mem_addr[g] = '0; mem_write_en[g] = '0; mem_write_data[g] = '0; lg[g] = 0;
    end
    tick(); tick();
    for (int g = 0; g < N; g++) rst[g] = 0;
    tick();
    for (int g = 0; g < N; g++) begin
      chk($sformatf("rst_ram_en%0d", g), ram_en[g], 0);
      chk($sformatf("rst_ram_we%0d", g), 32'(ram_write_en[g]), 0);
      chk($sformatf("rst_ram_addr%0d", g), ram_addr[g], 0);
      chk($sformatf("rst_ram_wdata%0d", g), ram_write_data[g], 0);
      chk($sformatf("rst_dones%0d", g), {if_done[g], mem_done[g]}, 0);
      chk($sformatf("rst_if_rdata%0d", g), if_rdata[g], 0);
      chk($sformatf("rst_mem_rdata%0d", g), mem_rdata[g], 0);
      chk($sformatf("rst_state%0d", g), dbg_state[g], 0);
      chk($sformatf("rst_stall%0d", g), {stall_if[g], stall_mem[g]}, 0);
    end

    // Directed single-requester vectors on the LATENCY=2 instance.
    vt[0] = '{0, 32'h0000_0100, 4'h0, 32'h0,         32'hDEADBEEF, 32'h0000_0000};
    vt[1] = '{1, 32'h0000_2004, 4'h3, 32'h0000_ABCD, 32'hDEADBEEF, 32'h0000_0000};
    vt[2] = '{1, 32'h0000_3000, 4'h0, 32'h0,         32'hDEADBEEF, 32'hFFFF_CFFF};
    vt[3] = '{0, 32'h0000_0044, 4'h0, 32'h0,         32'hFFFF_FFBB, 32'hFFFF_CFFF};
    vt[4] = '{1, 32'h0000_0008, 4'hF, 32'h1234_5678, 32'hFFFF_FFBB, 32'hFFFF_CFFF};
    vt[5] = '{0, 32'hFFFF_FFFF, 4'h0, 32'h0,         32'h0000_0000, 32'hFFFF_CFFF};
    for (int i = 0; i < 6; i++) begin
      do_txn(0, vt[i].is_mem, vt[i].addr, vt[i].we, vt[i].wdata);
      chk($sformatf("vec%0d_if_rdata", i), if_rdata[0], vt[i].exp_if);
      chk($sformatf("vec%0d_mem_rdata", i), mem_rdata[0], vt[i].exp_mem);
    end

    // mem_req dropped after the first ACCESS cycle still completes.
    mem_req[0] = 1; mem_addr[0] = 32'h44; mem_write_en[0] = 4'h0;
    tick(); tick();
    mem_req[0] = 0;
    wait_done(0, 10, got, own, n);
    chk("drop_owner", own, 1);
    chk("drop_latency", n + 2, l0 + 1);
    chk("drop_rdata", mem_rdata[0], 32'hFFFF_FFBB);
    chk("drop_stall", stall_mem[0], 0);
    tick();
    chk("drop_idle", dbg_state[0], 0);

    // Both sides held after reset: strict alternation, MEM first.
    rst[0] = 1; tick(); rst[0] = 0;
    lg[0] = 0; m_if_rd = '0; m_mem_rd = '0;
    if_addr[0] = 32'h100; mem_addr[0] = 32'h3000; mem_write_en[0] = '0; mem_write_data[0] = '0;
    if_req[0] = 1; mem_req[0] = 1;
    for (int k = 0; k < 4; k++) begin
      w = ~lg[0];
      exp_q.push_back({w, w ? ram_fn(32'h3000) : ram_fn(32'h100)});
      lg[0] = w;
      wait_done(0, 20, got, own, n);
      chk($sformatf("alt%0d_spacing", k), n, (k == 0) ? l0 + 1 : l0 + 2);
      eq = exp_q.pop_front();
      chk($sformatf("alt%0d_owner", k), own, eq[32]);
      chk($sformatf("alt%0d_rdata", k), eq[32] ? mem_rdata[0] : if_rdata[0], eq[31:0]);
      if (eq[32]) m_mem_rd = eq[31:0]; else m_if_rd = eq[31:0];
    end
    if_req[0] = 0; mem_req[0] = 0;
    tick();

    // Random traffic against a transaction-level model of the arbiter.
    pend[0] = 0; pend[1] = 0; p_we = '0; p_wd = '0;
    p_addr[0] = '0; p_addr[1] = '0;
    first = 1;
    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < 2; s++) begin
        if (!pend[s] && $urandom_range(0, 2) != 0) begin
          pend[s] = 1;
          p_addr[s] = $urandom;
          if (s == 1) begin
            p_we = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            p_wd = $urandom;
          end
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1;
        p_addr[0] = $urandom;
      end
      if_req[0] = pend[0]; if_addr[0] = p_addr[0];
      mem_req[0] = pend[1]; mem_addr[0] = p_addr[1];
      mem_write_en[0] = p_we; mem_write_data[0] = p_wd;
      w = (pend[0] && pend[1]) ? ~lg[0] : pend[1];
      if (w && p_we != 4'h0) e = m_mem_rd;
      else e = ram_fn(p_addr[w]);
      exp_q.push_back({w, e});
      wait_done(0, 20, got, own, n);
      chk("rnd_spacing", n, first ? l0 + 1 : l0 + 2);
      first = 0;
      eq = exp_q.pop_front();
      chk("rnd_owner", own, eq[32]);
      chk("rnd_rdata", eq[32] ? mem_rdata[0] : if_rdata[0], eq[31:0]);
      chk("rnd_other_rdata", eq[32] ? if_rdata[0] : mem_rdata[0], eq[32] ? m_if_rd : m_mem_rd);
      if (w) m_mem_rd = e; else m_if_rd = e;
      lg[0] = w;
      pend[w] = 0;
      if (w) mem_req[0] = 0; else if_req[0] = 0;
    end
    if_req[0] = 0; mem_req[0] = 0;
    tick(); tick();
    chk("rnd_end_idle", dbg_state[0], 0);

    // Reset in the second ACCESS cycle (LATENCY=4) aborts without a done.
    if_req[1] = 1; if_addr[1] = 32'h100;
    tick(); tick();
    chk("abort_pre_en", ram_en[1], 1);
    rst[1] = 1;
    tick();
    rst[1] = 0; if_req[1] = 0;
    chk("abort_ram_en", ram_en[1], 0);
    chk("abort_state", dbg_state[1], 0);
    any_done = 0;
    for (int k = 0; k < 8; k++) begin
      any_done = any_done | if_done[1] | mem_done[1];
      tick();
    end
    chk("abort_no_done", any_done, 0);
    chk("abort_rdata", if_rdata[1], 0);
    do_txn(1, 0, 32'h100, 4'h0, 32'h0);
    chk("abort_then_read", if_rdata[1], 32'hDEADBEEF);

    // Latency extremes.
    do_txn(2, 0, 32'h44, 4'h0, 32'h0);
    chk("lat1_rdata", if_rdata[2], 32'hFFFF_FFBB);
    do_txn(2, 1, 32'h10, 4'hF, 32'hCAFE_F00D);
    chk("lat1_wr_rdata", mem_rdata[2], 32'h0);
    do_txn(3, 1, 32'h3000, 4'h0, 32'h0);
    chk("lat15_rdata", mem_rdata[3], 32'hFFFF_CFFF);
    do_txn(3, 0, 32'h100, 4'h0, 32'h0);
    chk("lat15_if_rdata", if_rdata[3], 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter LATENCY, default 2, meaning RAM access cycles per transaction (legal 1..15).
REQ-002 The module SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, meaning synchronous reset, active-high.
REQ-004 The module SHALL have IF-side ports if_req (in, 1), if_addr (in, ADDR_BUS), if_done (out, 1) and if_rdata (out, DATA_BUS); the IF side is read-only.
REQ-005 The module SHALL have MEM-side ports mem_req (in, 1), mem_addr (in, ADDR_BUS), mem_write_en (in, MEM_SEL_BUS, byte enables, 0 = read), mem_write_data (in, DATA_BUS), mem_done (out, 1) and mem_rdata (out, DATA_BUS).
REQ-006 The module SHALL have shared-RAM ports ram_en (out, 1), ram_write_en (out, MEM_SEL_BUS), ram_addr (out, ADDR_BUS), ram_write_data (out, DATA_BUS) and ram_read_data (in, DATA_BUS).
REQ-007 The module SHALL have outputs stall_if and stall_mem (1 bit each), meaning a pipeline stall request per side.

Function
REQ-008 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-009 IDLE: if no request is pending, the FSM SHALL stay in IDLE; if only one side requests, that side SHALL be granted; if both request, the side not equal to last_grant SHALL win.
REQ-010 On a grant, the FSM SHALL go to ACCESS, latch the owner, address, byte enables and write data into the ram_* registers, set ram_en=1, clear the counter and update last_grant to the owner.
REQ-011 For an IF grant, ram_write_en SHALL be 0 and ram_write_data SHALL be 0.
REQ-012 ACCESS SHALL last exactly LATENCY cycles, with ram_* held stable and ram_en=1; the counter SHALL be 4 bits and increment by 1 per ACCESS cycle.
REQ-013 In the last ACCESS cycle (counter == LATENCY-1), a read SHALL capture ram_read_data into the owner's rdata register, and the FSM SHALL go to DONE with ram_en=0 and ram_write_en=0.
REQ-014 A write SHALL leave the owner's rdata register unchanged.
REQ-015 DONE SHALL last one cycle, with the owner's done=1 and the other side's done=0, then go to IDLE.
REQ-016 Latency: from the IDLE cycle in which a request is granted to the done pulse SHALL be LATENCY+1 cycles; back-to-back throughput SHALL be one transaction per LATENCY+2 cycles.
REQ-017 Requesters SHALL hold req, addr and data stable until done; the arbiter samples these only in IDLE.
REQ-018 A req dropped mid-transaction SHALL NOT abort the transaction; it completes and done pulses regardless.
REQ-019 stall_if SHALL equal if_req && !if_done, and stall_mem SHALL equal mem_req && !mem_done, combinationally.
REQ-020 rdata outputs SHALL hold their value until the next read completes for the same side.

Reset
REQ-021 While rst=1 at a clock edge, the block SHALL enter IDLE, clear ram_en, ram_write_en, ram_addr, ram_write_data, if_done, mem_done, if_rdata, mem_rdata and the counter, and set last_grant=IF so that MEM wins the first conflict.
REQ-022 A reset asserted during ACCESS or DONE SHALL abort the transaction with no done pulse, and ram_en SHALL be 0 from the cycle after the reset edge.

Structure
REQ-023 ADDR_BUS, DATA_BUS and MEM_SEL_BUS SHALL come from the shared bus definitions include; the state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and owner encodings (IF=1'b0, MEM=1'b1) SHALL live in a shared arbiter definitions include.
REQ-024 The block SHALL be a single flat module with no sub-module; the round-robin pick is local combinational logic.

Verification
REQ-025 Single IF read, LATENCY=2, if_addr=0x100, RAM returns 0xDEADBEEF: ram_en high exactly 2 cycles with ram_addr=0x100; if_done pulses 3 cycles after the grant cycle; if_rdata=0xDEADBEEF; stall_if high until the if_done cycle.
REQ-026 MEM write, mem_addr=0x2004, mem_write_en=4'b0011, mem_write_data=0x0000ABCD: ram_write_en=0011 during ACCESS; mem_done pulses; mem_rdata unchanged.
REQ-027 Simultaneous if_req and mem_req after reset, both held: grants go MEM, IF, MEM, IF in strict alternation, each pair of done pulses spaced LATENCY+2 cycles apart.
REQ-028 Reset pulsed in the 2nd ACCESS cycle with LATENCY=4: no done pulse; ram_en=0 the next cycle; a subsequent if_req is granted as a normal first transaction.
REQ-029 LATENCY=1 and LATENCY=15 sweeps: ACCESS length is exactly 1 and 15 cycles respectively; the counter never wraps.
REQ-030 mem_req dropped mid-ACCESS: the transaction completes, mem_done still pulses, and the FSM returns to IDLE.
